// File: rtl/banked_boot_mem.sv
// banked_boot_mem: unified instruction/data memory with byte-lane banks,
// multi-slot fetch, byte/half/word data port and a boot-load stream.
//
// Ports:
//   clock, reset (async, active-high), io_reset (sync soft reset of outputs)
//   io_reload, io_load_valid/ready/data/last, io_load_count, io_load_overflow
//   io_busy                  - high while INIT or LOAD
//   io_if_mem_instAddr       - fetch byte address
//   io_mem_id_inst           - FETCH_WIDTH consecutive words, slot k at [32k+:32]
//   io_ex_mem_*              - data port request (addr, readEn, writeEn, data, func3)
//   io_mem_lsu_data          - registered, extended load result
//   io_mem_fault             - one-cycle pulse with the result cycle
module banked_boot_mem #(
    parameter int DEPTH_WORDS = 16384,
    parameter int FETCH_WIDTH = 2,
    parameter int ADDR_WIDTH  = 64,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     io_reset,
    input  logic                     io_reload,
    input  logic                     io_load_valid,
    output logic                     io_load_ready,
    input  logic [31:0]              io_load_data,
    input  logic                     io_load_last,
    output logic [AW:0]              io_load_count,
    output logic                     io_load_overflow,
    output logic                     io_busy,
    input  logic [ADDR_WIDTH-1:0]    io_if_mem_instAddr,
    output logic [32*FETCH_WIDTH-1:0] io_mem_id_inst,
    input  logic [ADDR_WIDTH-1:0]    io_ex_mem_dataAddr,
    input  logic                     io_ex_mem_readEn,
    input  logic                     io_ex_mem_writeEn,
    input  logic [31:0]              io_ex_mem_writeData,
    input  logic [2:0]               io_ex_mem_func3,
    output logic [31:0]              io_mem_lsu_data,
    output logic                     io_mem_fault
);

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [AW:0] LAST_IDX = (AW + 1)'(DEPTH_WORDS - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_LOAD,
        ST_RUN
    } state_t;

    state_t                    r_state;
    logic [AW:0]               r_count;
    logic                      r_ovf;
    logic [32*FETCH_WIDTH-1:0] r_inst;
    logic [31:0]               r_lsu;
    logic                      r_fault;

    logic [7:0] r_bank [4][DEPTH_WORDS];

    logic                      w_run;
    logic                      w_load_fire;
    logic [AW-1:0]             w_fidx;
    logic [32*FETCH_WIDTH-1:0] w_fetch;
    logic [AW-1:0]             w_didx;
    logic [1:0]                w_lane;
    logic [31:0]               w_dword;
    logic [7:0]                w_byte;
    logic [15:0]               w_half;
    logic                      w_ld_bad;
    logic                      w_st_bad;
    logic                      w_ld_only;
    logic                      w_store_ok;
    logic [31:0]               w_ld_val;
    logic [3:0]                w_we;
    logic [31:0]               w_wd;
    logic [AW-1:0]             w_widx;
    logic                      w_unused;

    // Address bits above the memory size and the fetch byte offset are don't-care.
    assign w_unused = ^{io_if_mem_instAddr[ADDR_WIDTH-1:AW+2],
                        io_if_mem_instAddr[1:0],
                        io_ex_mem_dataAddr[ADDR_WIDTH-1:AW+2]};

    assign w_run       = (r_state == ST_RUN);
    assign w_load_fire = (r_state == ST_LOAD) && io_load_valid;
    assign w_fidx      = io_if_mem_instAddr[AW+1:2];
    assign w_didx      = io_ex_mem_dataAddr[AW+1:2];
    assign w_lane      = io_ex_mem_dataAddr[1:0];

    // Slot index wraps modulo the memory size through AW-bit addition.
    always_comb begin
        w_fetch = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            for (int b = 0; b < 4; b++) begin
                w_fetch[32*k+8*b +: 8] = r_bank[b][w_fidx + AW'(k)];
            end
        end
    end

    assign w_dword = {r_bank[3][w_didx], r_bank[2][w_didx],
                      r_bank[1][w_didx], r_bank[0][w_didx]};
    assign w_byte  = w_dword[{w_lane, 3'b000} +: 8];
    assign w_half  = w_lane[1] ? w_dword[31:16] : w_dword[15:0];

    always_comb begin
        w_ld_bad = 1'b1;
        w_ld_val = '0;
        case (io_ex_mem_func3)
            3'b000: begin
                w_ld_bad = 1'b0;
                w_ld_val = {{24{w_byte[7]}}, w_byte};
            end
            3'b001: begin
                w_ld_bad = w_lane[0];
                w_ld_val = {{16{w_half[15]}}, w_half};
            end
            3'b010: begin
                w_ld_bad = (w_lane != 2'b00);
                w_ld_val = w_dword;
            end
            3'b100: begin
                w_ld_bad = 1'b0;
                w_ld_val = {24'h0, w_byte};
            end
            3'b101: begin
                w_ld_bad = w_lane[0];
                w_ld_val = {16'h0, w_half};
            end
            default: begin
                w_ld_bad = 1'b1;
                w_ld_val = '0;
            end
        endcase
    end

    always_comb begin
        w_st_bad = 1'b1;
        case (io_ex_mem_func3)
            3'b000:  w_st_bad = 1'b0;
            3'b001:  w_st_bad = w_lane[0];
            3'b010:  w_st_bad = (w_lane != 2'b00);
            default: w_st_bad = 1'b1;
        endcase
    end

    assign w_ld_only  = io_ex_mem_readEn && !io_ex_mem_writeEn;
    assign w_store_ok = w_run && io_ex_mem_writeEn && !w_st_bad;

    // Boot beats and stores never coincide: one needs LOAD, the other RUN.
    always_comb begin
        w_we   = 4'b0000;
        w_wd   = '0;
        w_widx = w_didx;
        if (w_load_fire) begin
            w_we   = 4'b1111;
            w_wd   = io_load_data;
            w_widx = r_count[AW-1:0];
        end else if (w_store_ok) begin
            case (io_ex_mem_func3)
                3'b000: begin
                    w_we = 4'b0001 << w_lane;
                    w_wd = {4{io_ex_mem_writeData[7:0]}};
                end
                3'b001: begin
                    w_we = w_lane[1] ? 4'b1100 : 4'b0011;
                    w_wd = {2{io_ex_mem_writeData[15:0]}};
                end
                default: begin
                    w_we = 4'b1111;
                    w_wd = io_ex_mem_writeData;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (w_we[b]) begin
                r_bank[b][w_widx] <= w_wd[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_INIT;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: r_state <= ST_LOAD;
                ST_LOAD: begin
                    if (io_load_valid) begin
                        r_count <= r_count + 1'b1;
                        if (io_load_last) begin
                            r_state <= ST_RUN;
                        end else if (r_count == LAST_IDX) begin
                            r_ovf   <= 1'b1;
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (io_reload) begin
                        r_state <= ST_LOAD;
                        r_count <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_inst  <= {FETCH_WIDTH{NOP}};
            r_lsu   <= '0;
            r_fault <= 1'b0;
        end else if (io_reset) begin
            r_inst  <= {FETCH_WIDTH{NOP}};
            r_lsu   <= '0;
            r_fault <= 1'b0;
        end else begin
            r_inst  <= w_run ? w_fetch : {FETCH_WIDTH{NOP}};
            r_fault <= 1'b0;
            if (io_ex_mem_writeEn) begin
                // Stores leave the load result untouched, even with readEn.
                r_fault <= w_run && w_st_bad;
            end else if (w_ld_only) begin
                r_lsu   <= (w_run && !w_ld_bad) ? w_ld_val : 32'h0;
                r_fault <= w_run && w_ld_bad;
            end
        end
    end

    assign io_load_ready    = (r_state == ST_LOAD);
    assign io_busy          = !w_run;
    assign io_load_count    = r_count;
    assign io_load_overflow = r_ovf;
    assign io_mem_id_inst   = r_inst;
    assign io_mem_lsu_data  = r_lsu;
    assign io_mem_fault     = r_fault;

endmodule
